conv_zero_ctrl: RTL

Sequencer for the zero-point-add + ReLU requantisation stage that follows the convolution shifter. It latches a per-layer zero point and the feature-map geometry, admits accumulator beats from upstream only when the downstream output FIFO has space, and drives the stage's input-valid strobe. The stage itself cannot stall, so admission is gated by credits. The block also regenerates output-aligned valid/row-end/frame-end flags across the fixed datapath latency, and reports busy/done to the layer scheduler.

---
 rtl/conv_zero_ctrl_if.sv | 22 ++
 rtl/conv_zero_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/conv_zero_ctrl_if.sv
// Beat handshake, datapath strobe and output-flag bundle between the zero/ReLU
// sequencer (slave) and its surrounding upstream/downstream logic (master).
interface conv_zero_ctrl_if;
    logic       s_valid;
    logic       s_ready;
    logic       dp_valid;
    logic [7:0] dp_zero;
    logic       credit_ret;
    logic       m_valid;
    logic       m_last_row;
    logic       m_last;

    modport master (
        output s_valid, credit_ret,
        input  s_ready, dp_valid, dp_zero, m_valid, m_last_row, m_last
    );

    modport slave (
        input  s_valid, credit_ret,
        output s_ready, dp_valid, dp_zero, m_valid, m_last_row, m_last
    );
endinterface

// File: rtl/conv_zero_ctrl.sv
// Credit-gated sequencer for the zero-point-add + ReLU stage: admits beats, holds
// the layer zero point and regenerates output-aligned valid/row/frame flags.
module conv_zero_ctrl #(
    parameter int PIPE_LAT     = 2,
    parameter int CREDIT_DEPTH = 16,
    parameter int WIDTH_CNT    = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           zero_point_in,
    input  logic [WIDTH_CNT-1:0] col_num,
    input  logic [WIDTH_CNT-1:0] row_num,
    conv_zero_ctrl_if.slave      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 credit_err
);

    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH_CNT-1:0] col_q, row_q, cols_q, rows_q;
    logic [7:0]           zp_q;
    logic [CW-1:0]        credits_q;
    logic                 err_q;
    logic [PIPE_LAT-1:0]  vld_p, row_end_p, frame_end_p;
    logic [PIPE_LAT-1:0]  vld_shift;

    logic have_credit, credits_full, accept, col_last, row_last;
    logic row_end, frame_end, drained, start_ok;

    assign have_credit  = (credits_q != '0);
    assign credits_full = (credits_q == CW'(CREDIT_DEPTH));
    assign accept       = (state_q == RUN) && bus.s_valid && have_credit;
    assign col_last     = (col_q == cols_q - WIDTH_CNT'(1));
    assign row_last     = (row_q == rows_q - WIDTH_CNT'(1));
    assign row_end      = accept && col_last;
    assign frame_end    = row_end && row_last;
    assign start_ok     = (state_q == IDLE) && start;

    // In FLUSH nothing new enters, so the line is empty after this edge once
    // only the output stage (or nothing) still holds a valid beat.
    assign vld_shift = vld_p << 1;
    assign drained   = (vld_shift == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (col_num == '0 || row_num == '0) state_d = DONE;
                    else                                state_d = RUN;
                end
            end
            RUN:     if (frame_end) state_d = FLUSH;
            FLUSH:   if (drained)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_ready    = (state_q == RUN) && have_credit;
    assign bus.dp_valid   = accept;
    assign bus.dp_zero    = zp_q;
    assign bus.m_valid    = vld_p[PIPE_LAT-1];
    assign bus.m_last_row = row_end_p[PIPE_LAT-1];
    assign bus.m_last     = frame_end_p[PIPE_LAT-1];
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign credit_err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            cols_q <= '0;
            rows_q <= '0;
            zp_q   <= '0;
        end else if (start_ok) begin
            col_q  <= '0;
            row_q  <= '0;
            cols_q <= col_num;
            rows_q <= row_num;
            zp_q   <= zero_point_in;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_q + WIDTH_CNT'(1);
            end else begin
                col_q <= col_q + WIDTH_CNT'(1);
            end
        end
    end

    // Credits mirror free slots in the downstream FIFO and survive across layers.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CW'(CREDIT_DEPTH);
            err_q     <= 1'b0;
        end else begin
            case ({accept, bus.credit_ret})
                2'b10: credits_q <= credits_q - CW'(1);
                2'b01: begin
                    if (credits_full) err_q     <= 1'b1;
                    else              credits_q <= credits_q + CW'(1);
                end
                default: credits_q <= credits_q;
            endcase
        end
    end

    // Output-alignment delay lines, PIPE_LAT deep
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p       <= '0;
            row_end_p   <= '0;
            frame_end_p <= '0;
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                vld_p[i]       <= vld_p[i-1];
                row_end_p[i]   <= row_end_p[i-1];
                frame_end_p[i] <= frame_end_p[i-1];
            end
            vld_p[0]       <= accept;
            row_end_p[0]   <= row_end;
            frame_end_p[0] <= frame_end;
        end
    end

endmodule
